nn_conv_sequencer: RTL and testbench
====================================

// Module: nn_conv_sequencer
// PURPOSE
//  Control/scheduling block for the NN convolution datapath.
//  - Tracks the streamed Opt, Kernel1-3 and Image1-3 load phases and generates write addresses for the operand buffers.
//  - Then sequences the shared FP MAC over every output pixel, channel and kernel tap, including padding and address clamping.
//  - Times out_valid against the MAC pipeline latency. Holds no float data itself.
// PARAMETERS
//  IMG_DIM  4  image side length; image is IMG_DIM x IMG_DIM per channel
//  KER_DIM  3  kernel side length (odd); padding = KER_DIM/2
//  CH_NUM   3  number of channels, each on its own Image/Kernel bus
//  MAC_LAT  4  cycles from mac_valid issue to result at datapath output
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  in_valid_o   in   1   Opt beat valid (single cycle)
//  opt          in   2   [1]=1 replicate pad, 0 zero pad; [0]=activation select
//  in_valid_k   in   1   kernel beat valid, KER_DIM^2 beats
//  in_valid_i   in   1   image beat valid, IMG_DIM^2 beats
//  ker_wr_en    out  1   write strobe, all channel kernel buffers
//  ker_wr_addr  out  4   kernel buffer write address, 0..KER_DIM^2-1
//  img_wr_en    out  1   write strobe, all channel image buffers
//  img_wr_addr  out  4   image buffer write address, 0..IMG_DIM^2-1
//  mac_valid    out  1   MAC operand issue
//  mac_first    out  1   clear accumulator with this issue (ch 0, tap 0)
//  mac_last     out  1   final issue of one output pixel (ch CH_NUM-1, last tap)
//  ch_sel       out  2   channel operand mux select
//  img_rd_addr  out  4   image read address, clamped neighbour
//  ker_rd_addr  out  4   kernel read address = tap
//  pad_zero     out  1   force image operand to +0.0
//  act_sel      out  1   latched opt[0] to the activation stage
//  out_valid    out  1   one-cycle pulse per finished output pixel
//  busy         out  1   high outside IDLE
// BEHAVIOUR
//  Reset: every output is 0, FSM in IDLE, opt register is 2'b00, all counters are 0.
//  All outputs are registered.
//  FSM states:
//  - IDLE -> LOAD on the first in_valid_k or in_valid_i.
//  - LOAD -> CALC the cycle after both kernel count == KER_DIM^2 and image count == IMG_DIM^2.
//  - CALC -> DRAIN after the last issue.
//  - DRAIN -> IDLE after the last out_valid.
//  Opt: sampled on in_valid_o in IDLE or LOAD; retained across runs when no new beat arrives.
//  Loads:
//  - Kernel and image streams may overlap or arrive in either order.
//  - Each beat asserts *_wr_en with the current address; the address increments per beat.
//  - Final kernel and image beats in the same cycle are legal; CALC starts the next cycle.
//  CALC:
//  - Nested counters: pix 0..IMG_DIM^2-1 (outer), ch 0..CH_NUM-1, tap 0..KER_DIM^2-1 (inner).
//  - One issue per cycle: 432 issues with the defaults.
//  - Neighbour coordinates: (r+tr-1, c+tc-1).
//  - Out of bounds with opt[1]=0: pad_zero=1 and img_rd_addr is don't-care-but-clamped.
//  - Out of bounds with opt[1]=1: coordinates are clamped to 0..IMG_DIM-1 and pad_zero=0.
//  out_valid: equals mac_last delayed by exactly MAC_LAT+1 cycles through a shift register.
//  - Exactly IMG_DIM^2 pulses per run, spaced CH_NUM*KER_DIM^2 cycles apart.
//  - DRAIN ends the cycle after the last pulse.
//  Beats while busy in CALC/DRAIN: in_valid_i/k/o are ignored; buffers and opt are not written.
//  Reset mid-operation: immediate return to IDLE; pending out_valid pulses are discarded.
// CONFIGURATION
//  NN_SEQ_STALL_EN defined:
//  - Adds input mac_ready (1 bit).
//  - In CALC with mac_ready=0, the counters hold and mac_valid/first/last are 0.
//  - Address outputs hold their values.
//  - The out_valid delay line advances every cycle, because the MAC pipeline is not stalled.
//  NN_SEQ_STALL_EN undefined: no mac_ready port; CALC issues every cycle.
// STRUCTURE
//  Package nn_seq_pkg:
//  - state enum {IDLE, LOAD, CALC, DRAIN}
//  - PAD = KER_DIM/2
//  - IMG_AW / KER_AW address widths
//  - opt bit index constants OPT_PAD, OPT_ACT
//  Sub-module nn_seq_addr_gen (combinational): (pix, tap, pad_mode) -> img_rd_addr, pad_zero.
// TESTING
//  1 Reset mid-CALC (rst at issue 100): next cycle all outputs 0, busy=0; no out_valid afterwards.
//  2 Opt=2'b00; 9 kernel beats then 16 image beats:
//    - ker_wr_addr 0..8, img_wr_addr 0..15
//    - first mac_valid 1 cycle after last image beat
//    - pix0 tap0: pad_zero=1; pix0 tap4: img_rd_addr=0
//  3 Opt=2'b10 (replicate): pix0 tap0 -> pad_zero=0, img_rd_addr=0; pix15 tap8 -> img_rd_addr=15.
//  4 Overlapped loads, final kernel and image beats in the same cycle:
//    - CALC entered next cycle
//    - exactly 432 mac_valid; 16 mac_first; 16 mac_last
//  5 MAC_LAT=4: out_valid 5 cycles after each mac_last; 16 pulses; busy falls 1 cycle after the 16th.
//  6 NN_SEQ_STALL_EN with mac_ready low for 10 cycles mid-CALC: still 432 issues; no counter skips; last pulse 10 cycles later.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the convolution sequencer: FSM states, default geometry,
// address widths and opt bit positions.
package nn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CALC  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_IMG_DIM = 4;
    localparam int DEF_KER_DIM = 3;
    localparam int DEF_CH_NUM  = 3;
    localparam int DEF_MAC_LAT = 4;

    localparam int PAD    = DEF_KER_DIM / 2;
    localparam int IMG_AW = $clog2(DEF_IMG_DIM * DEF_IMG_DIM);
    localparam int KER_AW = $clog2(DEF_KER_DIM * DEF_KER_DIM);
    localparam int CH_W   = 2;

    localparam int OPT_PAD = 1;
    localparam int OPT_ACT = 0;

endpackage

// File: rtl/nn_seq_addr_gen.sv
// Combinational neighbour address generator: maps (output pixel, kernel tap) to a clamped
// image read address and flags out-of-bounds taps for zero padding.
module nn_seq_addr_gen
    import nn_seq_pkg::*;
#(
    parameter int IMG_DIM = DEF_IMG_DIM,
    parameter int KER_DIM = DEF_KER_DIM,
    parameter int PADDING = PAD
) (
    input  logic [IMG_AW-1:0] pix,
    input  logic [KER_AW-1:0] tap,
    input  logic              pad_mode,
    output logic [IMG_AW-1:0] img_rd_addr,
    output logic              pad_zero
);

    int   w_row, w_col, w_tr, w_tc, w_nr, w_nc, w_cr, w_cc;
    logic w_oob;

    always_comb begin
        w_row = int'(pix) / IMG_DIM;
        w_col = int'(pix) % IMG_DIM;
        w_tr  = int'(tap) / KER_DIM;
        w_tc  = int'(tap) % KER_DIM;
        w_nr  = w_row + w_tr - PADDING;
        w_nc  = w_col + w_tc - PADDING;
        w_oob = (w_nr < 0) || (w_nr > IMG_DIM - 1) || (w_nc < 0) || (w_nc > IMG_DIM - 1);
        // Clamping serves replicate padding and keeps zero-pad reads inside the buffer
        w_cr  = (w_nr < 0) ? 0 : ((w_nr > IMG_DIM - 1) ? IMG_DIM - 1 : w_nr);
        w_cc  = (w_nc < 0) ? 0 : ((w_nc > IMG_DIM - 1) ? IMG_DIM - 1 : w_nc);
        img_rd_addr = IMG_AW'(w_cr * IMG_DIM + w_cc);
        pad_zero    = w_oob && !pad_mode;
    end

endmodule

// File: rtl/nn_conv_sequencer.sv
// Load/compute sequencer for the NN convolution datapath (write addresses, MAC issue, out_valid).
// Optional NN_SEQ_STALL_EN adds a mac_ready input that stalls issue in CALC.
module nn_conv_sequencer
    import nn_seq_pkg::*;
#(
    parameter int IMG_DIM = DEF_IMG_DIM,
    parameter int KER_DIM = DEF_KER_DIM,
    parameter int CH_NUM  = DEF_CH_NUM,
    parameter int MAC_LAT = DEF_MAC_LAT
) (
    input  logic              clk,
    input  logic              rst,
`ifdef NN_SEQ_STALL_EN
    input  logic              mac_ready,
`endif
    input  logic              in_valid_o,
    input  logic [1:0]        opt,
    input  logic              in_valid_k,
    input  logic              in_valid_i,
    output logic              ker_wr_en,
    output logic [KER_AW-1:0] ker_wr_addr,
    output logic              img_wr_en,
    output logic [IMG_AW-1:0] img_wr_addr,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    output logic [CH_W-1:0]   ch_sel,
    output logic [IMG_AW-1:0] img_rd_addr,
    output logic [KER_AW-1:0] ker_rd_addr,
    output logic              pad_zero,
    output logic              act_sel,
    output logic              out_valid,
    output logic              busy
);

    localparam int KER_TAPS = KER_DIM * KER_DIM;
    localparam int IMG_PIX  = IMG_DIM * IMG_DIM;
    localparam int KCW      = $clog2(KER_TAPS + 1);
    localparam int ICW      = $clog2(IMG_PIX + 1);

    state_t            r_state, w_state_next;
    logic [1:0]        r_opt;
    logic [KCW-1:0]    r_ker_cnt;
    logic [ICW-1:0]    r_img_cnt;
    logic [IMG_AW-1:0] r_pix;
    logic [CH_W-1:0]   r_ch;
    logic [KER_AW-1:0] r_tap;
    logic [ICW-1:0]    r_out_cnt;
    logic [MAC_LAT:0]  r_dly;

    logic              r_ker_wr_en, r_img_wr_en, r_mac_valid, r_mac_first, r_mac_last;
    logic              r_pad_zero, r_busy;
    logic [KER_AW-1:0] r_ker_wr_addr, r_ker_rd_addr;
    logic [IMG_AW-1:0] r_img_wr_addr, r_img_rd_addr;
    logic [CH_W-1:0]   r_ch_sel;

    logic              w_ready, w_load_ok, w_acc_k, w_acc_i, w_k_full_next, w_i_full_next;
    logic              w_issue, w_tap_end, w_ch_end, w_pix_end, w_last_issue, w_drain_done;
    logic [IMG_AW-1:0] w_img_addr;
    logic              w_pad_zero;

`ifdef NN_SEQ_STALL_EN
    assign w_ready = mac_ready;
`else
    assign w_ready = 1'b1;
`endif

    assign w_load_ok     = (r_state == IDLE) || (r_state == LOAD);
    assign w_acc_k       = w_load_ok && in_valid_k && (r_ker_cnt != KCW'(KER_TAPS));
    assign w_acc_i       = w_load_ok && in_valid_i && (r_img_cnt != ICW'(IMG_PIX));
    // Completion is judged on the counts including this cycle's beat, so CALC follows the final beat directly
    assign w_k_full_next = (r_ker_cnt + KCW'(w_acc_k)) == KCW'(KER_TAPS);
    assign w_i_full_next = (r_img_cnt + ICW'(w_acc_i)) == ICW'(IMG_PIX);

    assign w_issue      = (r_state == CALC) && w_ready;
    assign w_tap_end    = (r_tap == KER_AW'(KER_TAPS - 1));
    assign w_ch_end     = (r_ch == CH_W'(CH_NUM - 1));
    assign w_pix_end    = (r_pix == IMG_AW'(IMG_PIX - 1));
    assign w_last_issue = w_issue && w_tap_end && w_ch_end && w_pix_end;
    assign w_drain_done = r_dly[MAC_LAT] && (r_out_cnt == ICW'(IMG_PIX - 1));

    nn_seq_addr_gen #(
        .IMG_DIM (IMG_DIM),
        .KER_DIM (KER_DIM),
        .PADDING (KER_DIM / 2)
    ) u_addr_gen (
        .pix         (r_pix),
        .tap         (r_tap),
        .pad_mode    (r_opt[OPT_PAD]),
        .img_rd_addr (w_img_addr),
        .pad_zero    (w_pad_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid_k || in_valid_i) w_state_next = LOAD;
            LOAD:    if (w_k_full_next && w_i_full_next) w_state_next = CALC;
            CALC:    if (w_last_issue) w_state_next = DRAIN;
            DRAIN:   if (w_drain_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opt         <= 2'b00;
            r_ker_cnt     <= '0;
            r_img_cnt     <= '0;
            r_pix         <= '0;
            r_ch          <= '0;
            r_tap         <= '0;
            r_out_cnt     <= '0;
            r_dly         <= '0;
            r_ker_wr_en   <= 1'b0;
            r_img_wr_en   <= 1'b0;
            r_ker_wr_addr <= '0;
            r_img_wr_addr <= '0;
            r_mac_valid   <= 1'b0;
            r_mac_first   <= 1'b0;
            r_mac_last    <= 1'b0;
            r_ch_sel      <= '0;
            r_img_rd_addr <= '0;
            r_ker_rd_addr <= '0;
            r_pad_zero    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (w_load_ok && in_valid_o) r_opt <= opt;

            r_ker_wr_en <= w_acc_k;
            r_img_wr_en <= w_acc_i;
            if (r_state == CALC) begin
                r_ker_cnt <= '0;
                r_img_cnt <= '0;
            end else begin
                if (w_acc_k) begin
                    r_ker_wr_addr <= r_ker_cnt[KER_AW-1:0];
                    r_ker_cnt     <= r_ker_cnt + KCW'(1);
                end
                if (w_acc_i) begin
                    r_img_wr_addr <= r_img_cnt[IMG_AW-1:0];
                    r_img_cnt     <= r_img_cnt + ICW'(1);
                end
            end

            if (r_state != CALC) begin
                r_pix <= '0;
                r_ch  <= '0;
                r_tap <= '0;
            end else if (w_issue) begin
                if (w_tap_end) begin
                    r_tap <= '0;
                    if (w_ch_end) begin
                        r_ch  <= '0;
                        r_pix <= r_pix + IMG_AW'(1);
                    end else begin
                        r_ch <= r_ch + CH_W'(1);
                    end
                end else begin
                    r_tap <= r_tap + KER_AW'(1);
                end
            end

            r_mac_valid <= w_issue;
            r_mac_first <= w_issue && (r_ch == '0) && (r_tap == '0);
            r_mac_last  <= w_issue && w_ch_end && w_tap_end;
            // Operand addresses only move on an issue, so they hold through stalls
            if (w_issue) begin
                r_ch_sel      <= r_ch;
                r_img_rd_addr <= w_img_addr;
                r_ker_rd_addr <= r_tap;
                r_pad_zero    <= w_pad_zero;
            end

            r_dly <= {r_dly[MAC_LAT-1:0], r_mac_last};
            if (r_state == LOAD) begin
                r_out_cnt <= '0;
            end else if (r_dly[MAC_LAT]) begin
                r_out_cnt <= r_out_cnt + ICW'(1);
            end

            r_busy <= (w_state_next != IDLE);
        end
    end

    assign ker_wr_en   = r_ker_wr_en;
    assign ker_wr_addr = r_ker_wr_addr;
    assign img_wr_en   = r_img_wr_en;
    assign img_wr_addr = r_img_wr_addr;
    assign mac_valid   = r_mac_valid;
    assign mac_first   = r_mac_first;
    assign mac_last    = r_mac_last;
    assign ch_sel      = r_ch_sel;
    assign img_rd_addr = r_img_rd_addr;
    assign ker_rd_addr = r_ker_rd_addr;
    assign pad_zero    = r_pad_zero;
    assign act_sel     = r_opt[OPT_ACT];
    assign out_valid   = r_dly[MAC_LAT];
    assign busy        = r_busy;

endmodule

// File: tb/tb_nn_conv_sequencer.sv
// Directed self-checking bench for nn_conv_sequencer (default 4x4 image, 3x3 kernel, 3 channels, MAC_LAT 4).
module tb_nn_conv_sequencer;
    import nn_seq_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid_o = 1'b0;
    logic [1:0]        opt = 2'b00;
    logic              in_valid_k = 1'b0;
    logic              in_valid_i = 1'b0;
`ifdef NN_SEQ_STALL_EN
    logic              mac_ready = 1'b1;
`endif
    logic              ker_wr_en, img_wr_en, mac_valid, mac_first, mac_last;
    logic [KER_AW-1:0] ker_wr_addr, ker_rd_addr;
    logic [IMG_AW-1:0] img_wr_addr, img_rd_addr;
    logic [CH_W-1:0]   ch_sel;
    logic              pad_zero, act_sel, out_valid, busy;
    logic [26:0]       all_out;

    int errors = 0;
    int checks = 0;

    int rec_addr [432];
    int rec_pad  [432];
    int st_valid, st_first, st_last, st_out, st_pad, st_wr;
    int st_seq_err, st_lat_err, st_gap_err, st_first_cyc, st_last_out_cyc, st_fall_cyc;

    nn_conv_sequencer dut (
        .clk         (clk),
        .rst         (rst),
`ifdef NN_SEQ_STALL_EN
        .mac_ready   (mac_ready),
`endif
        .in_valid_o  (in_valid_o),
        .opt         (opt),
        .in_valid_k  (in_valid_k),
        .in_valid_i  (in_valid_i),
        .ker_wr_en   (ker_wr_en),
        .ker_wr_addr (ker_wr_addr),
        .img_wr_en   (img_wr_en),
        .img_wr_addr (img_wr_addr),
        .mac_valid   (mac_valid),
        .mac_first   (mac_first),
        .mac_last    (mac_last),
        .ch_sel      (ch_sel),
        .img_rd_addr (img_rd_addr),
        .ker_rd_addr (ker_rd_addr),
        .pad_zero    (pad_zero),
        .act_sel     (act_sel),
        .out_valid   (out_valid),
        .busy        (busy)
    );

    assign all_out = {ker_wr_en, ker_wr_addr, img_wr_en, img_wr_addr, mac_valid, mac_first,
                      mac_last, ch_sel, img_rd_addr, ker_rd_addr, pad_zero, act_sel, out_valid, busy};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams 9 kernel + 16 image beats back to back; opt beat optionally rides on beat opt_at.
    task automatic load_beats(input bit img_first, input int opt_at, input logic [1:0] opt_v);
        for (int b = 0; b < 25; b++) begin
            if (img_first) begin
                in_valid_i = (b < 16);
                in_valid_k = (b >= 16);
            end else begin
                in_valid_k = (b < 9);
                in_valid_i = (b >= 9);
            end
            in_valid_o = (b == opt_at);
            opt        = opt_v;
            step();
        end
        in_valid_i = 1'b0;
        in_valid_k = 1'b0;
        in_valid_o = 1'b0;
    endtask

    // Runs until busy drops (bounded) and gathers statistics; cycle 1 is the edge after the last load beat.
    task automatic collect(input int stall_at, input int inject_at);
        int q[$];
        int prev_out;
        int t;
        st_valid = 0; st_first = 0; st_last = 0; st_out = 0; st_pad = 0; st_wr = 0;
        st_seq_err = 0; st_lat_err = 0; st_gap_err = 0;
        st_first_cyc = -1; st_last_out_cyc = -1; st_fall_cyc = -1; prev_out = -1;
        for (int i = 0; i < 432; i++) begin
            rec_addr[i] = -1;
            rec_pad[i]  = -1;
        end
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (cyc == inject_at) begin
                in_valid_o = 1'b1; opt = 2'b00; in_valid_i = 1'b1; in_valid_k = 1'b1;
            end else if (cyc == inject_at + 1) begin
                in_valid_o = 1'b0; in_valid_i = 1'b0; in_valid_k = 1'b0;
            end
`ifdef NN_SEQ_STALL_EN
            if (cyc == stall_at) mac_ready = 1'b0;
            if (cyc == stall_at + 10) mac_ready = 1'b1;
`endif
            step();
            if (ker_wr_en || img_wr_en) st_wr++;
            if (mac_first) st_first++;
            if (mac_last) begin
                st_last++;
                q.push_back(cyc);
            end
            if (mac_valid) begin
                if (st_first_cyc < 0) st_first_cyc = cyc;
                if (st_valid < 432) begin
                    rec_addr[st_valid] = int'(img_rd_addr);
                    rec_pad[st_valid]  = int'(pad_zero);
                end
                if (int'(ker_rd_addr) != st_valid % 9 || int'(ch_sel) != (st_valid / 9) % 3 ||
                    mac_first != (st_valid % 27 == 0) || mac_last != (st_valid % 27 == 26))
                    st_seq_err++;
                if (pad_zero) st_pad++;
                st_valid++;
            end else if (mac_first || mac_last) begin
                st_seq_err++;
            end
            if (out_valid) begin
                st_out++;
                if (q.size() == 0) st_lat_err++;
                else begin
                    t = q.pop_front();
                    if (cyc - t != 5) st_lat_err++;
                end
                if (prev_out >= 0 && cyc - prev_out != 27) st_gap_err++;
                prev_out = cyc;
                st_last_out_cyc = cyc;
            end
            if (!busy) begin
                st_fall_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (all_out !== 27'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        rst = 1'b0;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
        checks++; if (all_out !== 27'd0) begin errors++; $display("FAIL reset_idle_outputs: got %h want 0", all_out); end
    endtask

    task automatic test_zero_pad();
        in_valid_o = 1'b1; opt = 2'b00;
        step();
        in_valid_o = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL opt_only_busy: got %b want 0", busy); end
        for (int k = 0; k < 9; k++) begin
            in_valid_k = 1'b1;
            step();
            checks++;
            if (ker_wr_en !== 1'b1 || int'(ker_wr_addr) != k) begin
                errors++; $display("FAIL ker_wr beat %0d: en=%b addr=%0d want en=1 addr=%0d", k, ker_wr_en, ker_wr_addr, k);
            end
        end
        in_valid_k = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid_i = 1'b1;
            step();
            checks++;
            if (img_wr_en !== 1'b1 || int'(img_wr_addr) != i) begin
                errors++; $display("FAIL img_wr beat %0d: en=%b addr=%0d want en=1 addr=%0d", i, img_wr_en, img_wr_addr, i);
            end
        end
        in_valid_i = 1'b0;
        checks++; if (mac_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zp_pre_issue: mac_valid=%b busy=%b want 0 1", mac_valid, busy); end
        collect(-1, -1);
        checks++; if (st_first_cyc != 1) begin errors++; $display("FAIL zp_first_issue_cycle: got %0d want 1", st_first_cyc); end
        checks++; if (rec_pad[0] != 1) begin errors++; $display("FAIL zp_pix0_tap0_pad: got %0d want 1", rec_pad[0]); end
        checks++; if (rec_addr[4] != 0 || rec_pad[4] != 0) begin errors++; $display("FAIL zp_pix0_tap4: addr=%0d pad=%0d want 0 0", rec_addr[4], rec_pad[4]); end
        checks++; if (rec_addr[135] != 0 || rec_pad[135] != 0) begin errors++; $display("FAIL zp_pix5_tap0: addr=%0d pad=%0d want 0 0", rec_addr[135], rec_pad[135]); end
        checks++; if (rec_pad[83] != 1) begin errors++; $display("FAIL zp_pix3_tap2_pad: got %0d want 1", rec_pad[83]); end
        checks++; if (rec_addr[179] != 11 || rec_pad[179] != 0) begin errors++; $display("FAIL zp_pix6_ch1_tap8: addr=%0d pad=%0d want 11 0", rec_addr[179], rec_pad[179]); end
        checks++; if (st_pad != 132) begin errors++; $display("FAIL zp_pad_count: got %0d want 132", st_pad); end
        checks++; if (st_seq_err != 0) begin errors++; $display("FAIL zp_sequence: errors %0d want 0", st_seq_err); end
        checks++; if (act_sel !== 1'b0) begin errors++; $display("FAIL zp_act_sel: got %b want 0", act_sel); end
    endtask

    task automatic test_replicate();
        step();
        in_valid_o = 1'b1; opt = 2'b10;
        step();
        in_valid_o = 1'b0;
        load_beats(1'b0, -1, 2'b00);
        collect(-1, -1);
        checks++; if (rec_addr[0] != 0 || rec_pad[0] != 0) begin errors++; $display("FAIL rp_pix0_tap0: addr=%0d pad=%0d want 0 0", rec_addr[0], rec_pad[0]); end
        checks++; if (rec_addr[413] != 15) begin errors++; $display("FAIL rp_pix15_tap8: addr=%0d want 15", rec_addr[413]); end
        checks++; if (rec_addr[431] != 15) begin errors++; $display("FAIL rp_last_issue_addr: addr=%0d want 15", rec_addr[431]); end
        checks++; if (rec_addr[83] != 3 || rec_pad[83] != 0) begin errors++; $display("FAIL rp_pix3_tap2: addr=%0d pad=%0d want 3 0", rec_addr[83], rec_pad[83]); end
        checks++; if (rec_addr[330] != 12) begin errors++; $display("FAIL rp_pix12_tap6: addr=%0d want 12", rec_addr[330]); end
        checks++; if (st_pad != 0) begin errors++; $display("FAIL rp_pad_count: got %0d want 0", st_pad); end
    endtask

    task automatic test_overlap();
        step();
        for (int c = 0; c < 16; c++) begin
            in_valid_i = 1'b1;
            in_valid_k = (c >= 7);
            step();
        end
        in_valid_i = 1'b0;
        in_valid_k = 1'b0;
        checks++;
        if (ker_wr_en !== 1'b1 || img_wr_en !== 1'b1 || int'(ker_wr_addr) != 8 || int'(img_wr_addr) != 15) begin
            errors++; $display("FAIL ov_final_beats: ken=%b kaddr=%0d ien=%b iaddr=%0d want 1 8 1 15", ker_wr_en, ker_wr_addr, img_wr_en, img_wr_addr);
        end
        collect(-1, 50);
        checks++; if (st_first_cyc != 1) begin errors++; $display("FAIL ov_first_issue_cycle: got %0d want 1", st_first_cyc); end
        checks++; if (st_valid != 432) begin errors++; $display("FAIL ov_mac_valid_count: got %0d want 432", st_valid); end
        checks++; if (st_first != 16) begin errors++; $display("FAIL ov_mac_first_count: got %0d want 16", st_first); end
        checks++; if (st_last != 16) begin errors++; $display("FAIL ov_mac_last_count: got %0d want 16", st_last); end
        checks++; if (st_wr != 0) begin errors++; $display("FAIL ov_ignored_beats_wr: strobes %0d want 0", st_wr); end
        checks++; if (st_pad != 0) begin errors++; $display("FAIL ov_opt_retained_pad: got %0d want 0", st_pad); end
    endtask

    task automatic test_out_timing();
        step();
        load_beats(1'b1, 16, 2'b11);
        collect(-1, -1);
        checks++; if (st_out != 16) begin errors++; $display("FAIL ot_pulse_count: got %0d want 16", st_out); end
        checks++; if (st_lat_err != 0) begin errors++; $display("FAIL ot_latency: errors %0d want 0", st_lat_err); end
        checks++; if (st_gap_err != 0) begin errors++; $display("FAIL ot_spacing: errors %0d want 0", st_gap_err); end
        checks++; if (st_last_out_cyc != 437) begin errors++; $display("FAIL ot_last_pulse_cycle: got %0d want 437", st_last_out_cyc); end
        checks++; if (st_fall_cyc != 438) begin errors++; $display("FAIL ot_busy_fall_cycle: got %0d want 438", st_fall_cyc); end
        checks++; if (act_sel !== 1'b1) begin errors++; $display("FAIL ot_act_sel: got %b want 1", act_sel); end
    endtask

`ifdef NN_SEQ_STALL_EN
    task automatic test_stall();
        step();
        load_beats(1'b0, -1, 2'b00);
        collect(200, -1);
        checks++; if (st_valid != 432) begin errors++; $display("FAIL st_issue_count: got %0d want 432", st_valid); end
        checks++; if (st_seq_err != 0) begin errors++; $display("FAIL st_sequence: errors %0d want 0", st_seq_err); end
        checks++; if (st_lat_err != 0 || st_out != 16) begin errors++; $display("FAIL st_pulses: lat_err=%0d out=%0d want 0 16", st_lat_err, st_out); end
        checks++; if (st_last_out_cyc != 447) begin errors++; $display("FAIL st_last_pulse_cycle: got %0d want 447", st_last_out_cyc); end
        checks++; if (st_fall_cyc != 448) begin errors++; $display("FAIL st_busy_fall_cycle: got %0d want 448", st_fall_cyc); end
    endtask
`endif

    task automatic test_reset_mid_calc();
        int n;
        int late;
        step();
        load_beats(1'b0, -1, 2'b00);
        n = 0;
        for (int cyc = 0; cyc < 300 && n < 100; cyc++) begin
            step();
            if (mac_valid) n++;
        end
        checks++; if (n != 100) begin errors++; $display("FAIL rm_reach_issue_100: got %0d issues want 100", n); end
        rst = 1'b1;
        step();
        checks++; if (all_out !== 27'd0) begin errors++; $display("FAIL rm_outputs_zero: got %h want 0", all_out); end
        rst = 1'b0;
        late = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            step();
            if (out_valid || mac_valid || busy) late++;
        end
        checks++; if (late != 0) begin errors++; $display("FAIL rm_quiet_after_reset: active cycles %0d want 0", late); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_pad();
        test_replicate();
        test_overlap();
        test_out_timing();
`ifdef NN_SEQ_STALL_EN
        test_stall();
`endif
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
